fc2_mac_sequencer: RTL and testbench

- Initiator side of the FC2 weight-ROM interface. Drives `count_1`, `count_2` and `flag_ful2` into the combinational FC2 weight ROM, and drives `count_2` to the activation buffer.
- Multiply-accumulates 30 inputs x 10 output neurons (300 weights) and emits one saturated 16-bit result per neuron.
- Sits between the FC1 output buffer and the classifier/argmax stage.

---
 rtl/fc2_pkg.sv | 36 +++
 rtl/fc2_mac_datapath.sv | 54 +++++
 rtl/fc2_mac_sequencer.sv | 100 ++++++++++
 tb/tb_fc2_mac_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc2_pkg.sv
// Shared constants, FSM state type and output saturation for the FC2 MAC sequencer.
package fc2_pkg;

    localparam int unsigned N_IN      = 30;
    localparam int unsigned N_OUT     = 10;
    localparam int unsigned DW        = 16;
    localparam int unsigned ACCW      = 40;
    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned PW        = 2 * DW;
    localparam int unsigned C1W       = 4;
    localparam int unsigned C2W       = 5;

    // Saturation limits of a DW-bit signed result, held at accumulator width.
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clamp an accumulator-width value into the signed 16-bit output range.
    function automatic logic signed [DW-1:0] sat16(input logic signed [ACCW-1:0] v);
        logic signed [DW-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DW-1:0];
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fc2_mac_datapath.sv
// Multiply-accumulate datapath: signed product, running sum, shift, saturate, result register.
module fc2_mac_datapath
    import fc2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 last,
    input  logic [C1W-1:0]       idx,
    input  logic signed [DW-1:0] act,
    input  logic signed [DW-1:0] weight,
    output logic                 out_valid,
    output logic [C1W-1:0]       out_idx,
    output logic signed [DW-1:0] out_data
);

    logic signed [PW-1:0]   prod_c;
    logic signed [ACCW-1:0] prod_ext_c;
    logic signed [ACCW-1:0] sum_c;
    logic signed [ACCW-1:0] acc;

    // Product of this cycle's activation and weight, folded into the running sum.
    always_comb begin
        prod_c     = PW'(act) * PW'(weight);
        prod_ext_c = ACCW'(prod_c);
        sum_c      = acc + prod_ext_c;
    end

    // Accumulator and result registers; the last term of a neuron emits and clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                acc <= '0;
            end else if (en) begin
                if (last) begin
                    acc       <= '0;
                    out_data  <= sat16(sum_c >>> FRAC_BITS);
                    out_idx   <= idx;
                    out_valid <= 1'b1;
                end else begin
                    acc <= sum_c;
                end
            end
        end
    end

endmodule

// File: rtl/fc2_mac_sequencer.sv
// FC2 weight-ROM initiator: walks 10 neurons x 30 inputs and emits one saturated result per neuron.
module fc2_mac_sequencer
    import fc2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 hold,
    output logic [C1W-1:0]       count_1,
    output logic [C2W-1:0]       count_2,
    output logic                 flag_ful2,
    input  logic signed [DW-1:0] weight_ful2,
    input  logic signed [DW-1:0] act_data,
    output logic                 out_valid,
    output logic [C1W-1:0]       out_idx,
    output logic signed [DW-1:0] out_data,
    output logic                 busy,
    output logic                 done
);

    state_t state;
    logic   clr_c;
    logic   en_c;
    logic   last_c;

    // Datapath controls derived from the current state and counters.
    always_comb begin
        clr_c  = (state == IDLE) && start;
        en_c   = (state == RUN) && !hold;
        last_c = (count_2 == C2W'(N_IN));
    end

    // Sequencer FSM: counters, ROM enable and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count_1   <= '0;
            count_2   <= '0;
            flag_ful2 <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flag_ful2 <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        count_1   <= C1W'(1);
                        count_2   <= C2W'(1);
                        flag_ful2 <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        if (count_2 < C2W'(N_IN)) begin
                            count_2 <= count_2 + C2W'(1);
                        end else if (count_1 < C1W'(N_OUT)) begin
                            count_2 <= C2W'(1);
                            count_1 <= count_1 + C1W'(1);
                        end else begin
                            state     <= DONE;
                            flag_ful2 <= 1'b0;
                            count_1   <= '0;
                            count_2   <= '0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    flag_ful2 <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    fc2_mac_datapath u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_c),
        .en        (en_c),
        .last      (last_c),
        .idx       (count_1),
        .act       (act_data),
        .weight    (weight_ful2),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_fc2_mac_sequencer.sv
// Scoreboard bench for fc2_mac_sequencer with a behavioural ROM/activation model.
module tb_fc2_mac_sequencer;

    localparam int NI = 30;
    localparam int NO = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               hold;
    logic [3:0]         count_1;
    logic [4:0]         count_2;
    logic               flag_ful2;
    logic signed [15:0] weight_ful2;
    logic signed [15:0] act_data;
    logic               out_valid;
    logic [3:0]         out_idx;
    logic signed [15:0] out_data;
    logic               busy;
    logic               done;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    logic signed [15:0] rom [0:300];
    logic signed [15:0] act_mem [1:30];
    int                 visited [0:300];
    exp_t               sb_q [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int exp_done_lat = 301;

    fc2_mac_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .hold        (hold),
        .count_1     (count_1),
        .count_2     (count_2),
        .flag_ful2   (flag_ful2),
        .weight_ful2 (weight_ful2),
        .act_data    (act_data),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ROM and activation buffer, addressed by the DUT counters.
    always_comb begin
        int a;
        weight_ful2 = '0;
        act_data    = '0;
        a = 300 - int'(count_1) - 10 * (int'(count_2) - 1);
        if (flag_ful2 && a >= 0 && a <= 300) weight_ful2 = rom[a];
        if (count_2 >= 5'd1 && count_2 <= 5'd30) act_data = act_mem[count_2];
    end

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic set_pattern(input int mode);
        for (int a = 0; a < 300; a++) begin
            case (mode)
                1, 2:    rom[a] = 16'sd32767;
                5:       rom[a] = 16'(int'($urandom_range(0, 1023)) - 512);
                6:       rom[a] = 16'($urandom());
                default: rom[a] = 16'sd256;
            endcase
        end
        rom[300] = '0;
        for (int k = 1; k <= NI; k++) begin
            case (mode)
                1:       act_mem[k] = 16'sd32767;
                2:       act_mem[k] = -16'sd32768;
                3:       act_mem[k] = (k % 2 == 1) ? -16'sd256 : 16'sd256;
                4:       act_mem[k] = -16'sd256;
                5:       act_mem[k] = 16'(int'($urandom_range(0, 1023)) - 512);
                6:       act_mem[k] = 16'($urandom());
                default: act_mem[k] = 16'sd256;
            endcase
        end
    endtask

    // Reference: neuron n is the dot product of all activations with its weight column.
    task automatic push_expected();
        for (int n = 1; n <= NO; n++) begin
            longint s;
            exp_t   e;
            s = 0;
            for (int k = 1; k <= NI; k++) begin
                s += longint'(act_mem[k]) * longint'(rom[300 - n - 10 * (k - 1)]);
            end
            s = s >>> 8;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            e.idx  = n;
            e.data = int'(s);
            sb_q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_count_1", longint'(count_1), 0);
        check("rst_count_2", longint'(count_2), 0);
        check("rst_flag_ful2", longint'(flag_ful2), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_idx", longint'(out_idx), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
    endtask

    // Monitor: pops the scoreboard on each result, traces ROM addresses, checks timing.
    initial begin
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (out_valid) begin
                    check("valid_spacing", longint'(prev_valid), 0);
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_valid", longint'(out_idx), -1);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("out_idx", longint'(out_idx), e.idx);
                        check("out_data", longint'(out_data), e.data);
                        if (e.idx == 1) check("first_valid_latency", cyc - start_cyc, 31);
                    end
                end
                if (done) begin
                    check("done_with_valid", longint'(out_valid), 1);
                    check("done_busy", longint'(busy), 1);
                    check("done_latency", cyc - start_cyc, exp_done_lat);
                    check("done_queue_empty", sb_q.size(), 0);
                end
                if (flag_ful2 && !hold) begin
                    int a;
                    a = 300 - int'(count_1) - 10 * (int'(count_2) - 1);
                    check("addr_in_range", (a >= 0 && a <= 299) ? 1 : 0, 1);
                    if (a >= 0 && a <= 300) visited[a]++;
                end
                prev_valid = out_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic run_one(input int mode, input bit do_hold, input bit abuse, input bit do_abort);
        bit fin;
        bit aborted;
        bit hold_on;
        bit hold_used;
        int hold_cnt;
        int bad;
        set_pattern(mode);
        for (int a = 0; a <= 300; a++) visited[a] = 0;
        push_expected();
        exp_done_lat = do_hold ? 306 : 301;
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start     = 1'b0;
        fin = 0; aborted = 0; hold_on = 0; hold_used = 0; hold_cnt = 0;
        for (int i = 0; i < 400 && !fin && !aborted; i++) begin
            start = abuse && (i == 100);
            if (hold_on) begin
                check("hold_count_1", longint'(count_1), 3);
                check("hold_count_2", longint'(count_2), 17);
                check("hold_no_valid", longint'(out_valid), 0);
                hold_cnt++;
                if (hold_cnt == 5) begin
                    hold    = 1'b0;
                    hold_on = 1'b0;
                end
            end else if (do_hold && !hold_used && count_1 == 4'd3 && count_2 == 5'd17) begin
                hold      = 1'b1;
                hold_on   = 1'b1;
                hold_used = 1'b1;
            end
            if (do_abort && count_1 == 4'd4 && count_2 == 5'd5) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_reset_outputs();
                sb_q.delete();
                rst_n   = 1'b1;
                aborted = 1;
            end else if (done) begin
                fin = 1;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!aborted) begin
            check("done_seen", longint'(fin), 1);
            if (abuse && fin) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("idle_after_done_busy", longint'(busy), 0);
            check("idle_after_done_flag", longint'(flag_ful2), 0);
            bad = 0;
            for (int a = 0; a < 300; a++) if (visited[a] != 1) bad++;
            if (visited[300] != 0) bad++;
            check("addr_trace_bad", bad, 0);
        end else begin
            repeat (40) @(negedge clk);
            check("abort_stays_idle", longint'(busy), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        for (int a = 0; a <= 300; a++) rom[a] = '0;
        for (int k = 1; k <= NI; k++) act_mem[k] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        hold = 1'b1;
        @(negedge clk);
        hold = 1'b0;
        check("idle_hold_no_effect", longint'(busy), 0);

        run_one(0, 0, 0, 0);
        run_one(1, 0, 0, 0);
        run_one(2, 0, 0, 0);
        run_one(3, 0, 0, 0);
        run_one(4, 0, 0, 0);
        run_one(5, 0, 0, 0);
        run_one(6, 0, 0, 0);
        run_one(5, 1, 0, 0);
        run_one(5, 0, 1, 0);
        run_one(6, 0, 0, 1);
        run_one(0, 0, 0, 0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
